cannon_fire_ctrl: RTL and testbench

Initiator side of the cannon load/hold interface. Decides when a cannonball is armed, launched, frozen on impact and re-parked, by driving cannon_load/cannon_hold into the cannon motion block. It sits between the player/game-state logic and the cannon motion block. It also tracks ammunition and the per-shot frame timers.

---
 rtl/cannon_pkg.sv | 34 +++
 rtl/frame_timer.sv | 26 ++
 rtl/cannon_fire_ctrl.sv | 154 +++++++++++++++
 tb/tb_cannon_fire_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cannon_pkg.sv
// rtl/cannon_pkg.sv - shared states, load/hold encodings and timer width for the cannon fire controller
package cannon_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FLIGHT,
    IMPACT,
    COOLDOWN
  } fire_state_t;

  // {load, hold} driven into the cannon motion block
  localparam logic [1:0] LH_IDLE     = 2'b00;
  localparam logic [1:0] LH_ARM      = 2'b11;
  localparam logic [1:0] LH_FLIGHT   = 2'b10;
  localparam logic [1:0] LH_IMPACT   = 2'b01;
  localparam logic [1:0] LH_COOLDOWN = 2'b00;

  function automatic logic [1:0] load_hold(input fire_state_t s);
    logic [1:0] lh;
    lh = LH_IDLE;
    case (s)
      ARM:      lh = LH_ARM;
      FLIGHT:   lh = LH_FLIGHT;
      IMPACT:   lh = LH_IMPACT;
      COOLDOWN: lh = LH_COOLDOWN;
      default:  lh = LH_IDLE;
    endcase
    return lh;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - frame counter advanced on start-of-frame ticks with a runtime terminal compare
module frame_timer
  import cannon_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic [TIMER_W-1:0] i_last,
  output logic               o_at_last
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_tick && i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_last = (r_count == i_last);

endmodule

// File: rtl/cannon_fire_ctrl.sv
// rtl/cannon_fire_ctrl.sv - arms, launches, freezes and re-parks the cannonball; tracks ammo and shot timers
module cannon_fire_ctrl
  import cannon_pkg::*;
#(
  parameter int MAX_SHOTS         = 7,
  parameter int ARM_FRAMES        = 8,
  parameter int FLIGHT_MAX_FRAMES = 120,
  parameter int IMPACT_FRAMES     = 10,
  parameter int COOLDOWN_FRAMES   = 45,
  parameter int Y_EXIT            = 400
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_of_frame,
  input  logic        i_game_enable,
  input  logic        i_fire_req,
  input  logic        i_ball_hit,
  input  logic [10:0] i_ball_top_left_y,
  input  logic        i_refill,
  output logic        o_cannon_load,
  output logic        o_cannon_hold,
  output logic        o_shot_active,
  output logic        o_cooldown_busy,
  output logic        o_shot_fired,
  output logic        o_impact_by_hit,
  output logic [3:0]  o_ammo_left
);

  localparam logic [TIMER_W-1:0] ARM_LAST      = TIMER_W'(ARM_FRAMES - 1);
  localparam logic [TIMER_W-1:0] FLIGHT_LAST   = TIMER_W'(FLIGHT_MAX_FRAMES - 1);
  localparam logic [TIMER_W-1:0] IMPACT_LAST   = TIMER_W'(IMPACT_FRAMES - 1);
  localparam logic [TIMER_W-1:0] COOLDOWN_LAST = TIMER_W'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0]         AMMO_MAX      = 4'(MAX_SHOTS);
  localparam logic signed [10:0] Y_EXIT_S      = 11'(Y_EXIT);

  fire_state_t        r_state;
  fire_state_t        w_state_next;
  logic               w_end_by_hit;
  logic [TIMER_W-1:0] w_last;
  logic               w_at_last;
  logic               w_frame_done;
  logic               w_y_exit;
  logic               w_fire_accept;
  logic               w_flight_end;

  logic               r_load;
  logic               r_hold;
  logic               r_shot_active;
  logic               r_cooldown_busy;
  logic               r_shot_fired;
  logic               r_impact_by_hit;
  logic [3:0]         r_ammo_left;

  always_comb begin
    w_last = '0;
    case (r_state)
      ARM:      w_last = ARM_LAST;
      FLIGHT:   w_last = FLIGHT_LAST;
      IMPACT:   w_last = IMPACT_LAST;
      COOLDOWN: w_last = COOLDOWN_LAST;
      default:  w_last = '0;
    endcase
  end

  // The counter is zeroed on every state change so each timed state starts from 0.
  frame_timer u_frame_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_state_next != r_state),
    .i_tick    (i_start_of_frame),
    .i_enable  (r_state != IDLE),
    .i_last    (w_last),
    .o_at_last (w_at_last)
  );

  assign w_frame_done = i_start_of_frame && w_at_last;
  assign w_y_exit     = $signed(i_ball_top_left_y) >= Y_EXIT_S;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_end_by_hit = 1'b0;
    if (!i_game_enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_fire_req && (r_ammo_left != 4'd0)) w_state_next = ARM;
        end
        ARM: begin
          if (w_frame_done) w_state_next = FLIGHT;
        end
        FLIGHT: begin
          if (i_ball_hit) begin
            w_state_next = IMPACT;
            w_end_by_hit = 1'b1;
          end else if (w_y_exit || w_frame_done) begin
            w_state_next = IMPACT;
          end
        end
        IMPACT: begin
          if (w_frame_done) w_state_next = COOLDOWN;
        end
        COOLDOWN: begin
          if (w_frame_done) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_fire_accept = (r_state == IDLE) && (w_state_next == ARM);
  assign w_flight_end  = (r_state == FLIGHT) && (w_state_next == IMPACT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_load          <= 1'b0;
      r_hold          <= 1'b0;
      r_shot_active   <= 1'b0;
      r_cooldown_busy <= 1'b0;
      r_shot_fired    <= 1'b0;
      r_impact_by_hit <= 1'b0;
      r_ammo_left     <= AMMO_MAX;
    end else begin
      {r_load, r_hold} <= load_hold(w_state_next);
      r_shot_active    <= (w_state_next == ARM) || (w_state_next == FLIGHT);
      r_cooldown_busy  <= (w_state_next == IMPACT) || (w_state_next == COOLDOWN);
      r_shot_fired     <= (r_state == ARM) && (w_state_next == FLIGHT);
      if (w_flight_end) r_impact_by_hit <= w_end_by_hit;
      // A refill in the same cycle as an accepted fire leaves the magazine full.
      if (i_refill) begin
        r_ammo_left <= AMMO_MAX;
      end else if (w_fire_accept) begin
        r_ammo_left <= r_ammo_left - 4'd1;
      end
    end
  end

  assign o_cannon_load   = r_load;
  assign o_cannon_hold   = r_hold;
  assign o_shot_active   = r_shot_active;
  assign o_cooldown_busy = r_cooldown_busy;
  assign o_shot_fired    = r_shot_fired;
  assign o_impact_by_hit = r_impact_by_hit;
  assign o_ammo_left     = r_ammo_left;

endmodule

// File: tb/tb_cannon_fire_ctrl.sv
// tb/tb_cannon_fire_ctrl.sv - directed vector bench for cannon_fire_ctrl
module tb_cannon_fire_ctrl;

  logic        clk;
  logic        rst;
  logic        sof;
  logic        en;
  logic        fire;
  logic        hit;
  logic [10:0] y;
  logic        rf;

  logic        load;
  logic        hold;
  logic        act;
  logic        busy;
  logic        fired;
  logic        ibh;
  logic [3:0]  ammo;

  int n_cmp = 0;
  int n_bad = 0;

  // expected flag groups: {load, hold, shot_active, cooldown_busy, shot_fired, impact_by_hit}
  localparam logic [5:0] F_IDLE     = 6'b000000;
  localparam logic [5:0] F_IDLE_H   = 6'b000001;
  localparam logic [5:0] F_ARM      = 6'b111000;
  localparam logic [5:0] F_ARM_H    = 6'b111001;
  localparam logic [5:0] F_FLT      = 6'b101000;
  localparam logic [5:0] F_FLT_H    = 6'b101001;
  localparam logic [5:0] F_FIRED    = 6'b101010;
  localparam logic [5:0] F_IMP      = 6'b010100;
  localparam logic [5:0] F_IMP_H    = 6'b010101;
  localparam logic [5:0] F_COOL     = 6'b000100;
  localparam logic [5:0] F_COOL_H   = 6'b000101;
  localparam logic [10:0] Y_NEG     = 11'h7FB;

  typedef struct {
    logic        rst;
    logic        sof;
    logic        en;
    logic        fire;
    logic        hit;
    logic [10:0] y;
    logic        rf;
    logic [5:0]  flags;
    logic [3:0]  ammo;
  } vec_t;

  vec_t vq[$];

  cannon_fire_ctrl #(
    .MAX_SHOTS         (2),
    .ARM_FRAMES        (2),
    .FLIGHT_MAX_FRAMES (5),
    .IMPACT_FRAMES     (2),
    .COOLDOWN_FRAMES   (3),
    .Y_EXIT            (400)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_start_of_frame  (sof),
    .i_game_enable     (en),
    .i_fire_req        (fire),
    .i_ball_hit        (hit),
    .i_ball_top_left_y (y),
    .i_refill          (rf),
    .o_cannon_load     (load),
    .o_cannon_hold     (hold),
    .o_shot_active     (act),
    .o_cooldown_busy   (busy),
    .o_shot_fired      (fired),
    .o_impact_by_hit   (ibh),
    .o_ammo_left       (ammo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] exp_flags, input logic [3:0] exp_ammo);
    logic [9:0] got;
    logic [9:0] exp;
    got = {load, hold, act, busy, fired, ibh, ammo};
    exp = {exp_flags, exp_ammo};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got flags=%b ammo=%0d, expected flags=%b ammo=%0d",
               name, got[9:4], got[3:0], exp[9:4], exp[3:0]);
    end
  endtask

  task automatic sof_n(input int n);
    for (int k = 0; k < n; k++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
    end
  endtask

  task automatic addv(input logic r, input logic s, input logic f, input logic h,
                      input logic [10:0] yy, input logic [5:0] fl, input logic [3:0] am);
    vec_t v;
    v.rst = r; v.sof = s; v.en = 1'b1; v.fire = f; v.hit = h; v.y = yy; v.rf = 1'b0;
    v.flags = fl; v.ammo = am;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; en = 1'b1; fire = 1'b0; hit = 1'b0; y = '0; rf = 1'b0;

    // reset, then a full timed shot ending on the flight timeout
    addv(1, 0, 1, 0, 0,     F_IDLE,  2);
    addv(1, 0, 1, 0, 0,     F_IDLE,  2);
    addv(1, 0, 0, 0, 0,     F_IDLE,  2);
    addv(0, 0, 0, 0, 0,     F_IDLE,  2);
    addv(0, 0, 0, 0, 0,     F_IDLE,  2);
    addv(0, 0, 1, 0, 0,     F_ARM,   1);
    addv(0, 0, 0, 0, 0,     F_ARM,   1);
    addv(0, 1, 0, 0, 0,     F_ARM,   1);
    addv(0, 0, 0, 0, 0,     F_ARM,   1);
    addv(0, 1, 0, 0, 0,     F_FIRED, 1);
    addv(0, 0, 0, 0, Y_NEG, F_FLT,   1);
    addv(0, 1, 0, 0, Y_NEG, F_FLT,   1);
    addv(0, 1, 0, 0, 399,   F_FLT,   1);
    addv(0, 1, 0, 0, 0,     F_FLT,   1);
    addv(0, 0, 0, 0, 399,   F_FLT,   1);
    addv(0, 1, 0, 0, 0,     F_FLT,   1);
    addv(0, 1, 0, 0, 0,     F_IMP,   1);
    addv(0, 0, 0, 1, 0,     F_IMP,   1);
    addv(0, 1, 0, 0, 0,     F_IMP,   1);
    addv(0, 1, 0, 0, 0,     F_COOL,  1);
    addv(0, 0, 0, 1, 0,     F_COOL,  1);
    addv(0, 1, 0, 0, 0,     F_COOL,  1);
    addv(0, 1, 0, 0, 0,     F_COOL,  1);
    addv(0, 1, 0, 0, 0,     F_IDLE,  1);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; sof = vq[i].sof; en = vq[i].en; fire = vq[i].fire;
      hit = vq[i].hit; y = vq[i].y; rf = vq[i].rf;
      tick();
      check($sformatf("vec%0d", i), vq[i].flags, vq[i].ammo);
    end
    rst = 1'b0; sof = 1'b0; fire = 1'b0; hit = 1'b0; y = '0; rf = 1'b0;

    // mid-frame hit ends the flight
    fire = 1'b1; tick(); fire = 1'b0;
    check("hit_arm", F_ARM, 0);
    sof_n(1);
    sof = 1'b1; tick(); sof = 1'b0;
    check("hit_fired", F_FIRED, 0);
    hit = 1'b1; tick(); hit = 1'b0;
    check("hit_impact", F_IMP_H, 0);
    sof_n(2);
    check("hit_cool", F_COOL_H, 0);
    sof_n(3);
    check("hit_idle", F_IDLE_H, 0);

    // no ammo: held fire is ignored
    fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("empty%0d", i), F_IDLE_H, 0);
    end

    // refill with fire held: shot starts the following clk
    rf = 1'b1; tick(); rf = 1'b0;
    check("refill_idle", F_IDLE_H, 2);
    tick(); fire = 1'b0;
    check("refill_arm", F_ARM_H, 1);

    // Y exit boundary
    sof_n(2);
    check("exit_flight", F_FLT_H, 1);
    y = 11'd400; tick(); y = '0;
    check("exit_impact", F_IMP, 1);
    sof_n(5);
    check("exit_idle", F_IDLE, 1);

    // refill coincident with fire; hit beats exit
    fire = 1'b1; rf = 1'b1; tick(); fire = 1'b0; rf = 1'b0;
    check("rf_fire_arm", F_ARM, 2);
    sof_n(2);
    check("prio_flight", F_FLT, 2);
    hit = 1'b1; y = 11'd450; tick(); hit = 1'b0; y = '0;
    check("prio_impact", F_IMP_H, 2);
    sof_n(5);
    check("prio_idle", F_IDLE_H, 2);

    // held fire auto-repeats until the magazine is empty
    fire = 1'b1; tick();
    check("rep_arm1", F_ARM_H, 1);
    sof_n(2);
    check("rep_flight1", F_FLT_H, 1);
    sof_n(5);
    check("rep_impact1", F_IMP, 1);
    sof_n(2);
    check("rep_cool1", F_COOL, 1);
    sof_n(2);
    sof = 1'b1; tick(); sof = 1'b0;
    check("rep_idle1", F_IDLE, 1);
    tick();
    check("rep_arm2", F_ARM, 0);
    sof_n(12);
    check("rep_idle2", F_IDLE, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rep_hold%0d", i), F_IDLE, 0);
    end
    fire = 1'b0;

    // game_enable abort during flight
    rf = 1'b1; tick(); rf = 1'b0;
    check("abort_refill", F_IDLE, 2);
    fire = 1'b1; tick(); fire = 1'b0;
    check("abort_arm", F_ARM, 1);
    sof_n(2);
    check("abort_flight", F_FLT, 1);
    en = 1'b0; tick();
    check("abort_idle", F_IDLE, 1);
    fire = 1'b1; tick(); fire = 1'b0;
    check("abort_blocked", F_IDLE, 1);
    en = 1'b1;

    // reset during ARM
    fire = 1'b1; tick(); fire = 1'b0;
    check("rst_arm", F_ARM, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_vals", F_IDLE, 2);
    sof_n(2);
    check("rst_stay", F_IDLE, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
